// File: rtl/envelope.sv
// Volume envelope for the APU channels: a 4-bit decay level stepping down every n+1
// envelope ticks, with optional 0->15 looping or a constant-volume output of n.
module envelope (
    input  logic       clk,
    input  logic       resetFlag,
    input  logic       loop,
    input  logic       disableFlag,
    input  logic [3:0] n,
    output logic [3:0] volume
);

    logic [3:0] divider_q, divider_d;
    logic [3:0] decay_q,   decay_d;

    always_comb begin
        divider_d = divider_q;
        decay_d   = decay_q;
        if (divider_q != 4'd0) begin
            divider_d = divider_q - 4'd1;
        end else begin
            // Divider expiry: reload from the current n and step the decay level.
            divider_d = n;
            if (decay_q != 4'd0) begin
                decay_d = decay_q - 4'd1;
            end else if (loop) begin
                decay_d = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetFlag) begin
            divider_q <= n;
            decay_q   <= '1;
        end else begin
            divider_q <= divider_d;
            decay_q   <= decay_d;
        end
    end

    // Decay keeps running in constant mode; only the output selection changes.
    assign volume = disableFlag ? n : decay_q;

endmodule

// File: tb/tb_envelope.sv
// Directed self-checking bench for envelope: decay timing, looping, constant mode,
// divider period changes and mid-run restarts.
module tb_envelope;

    logic       clk = 1'b0;
    logic       resetFlag = 1'b0;
    logic       loop = 1'b0;
    logic       disableFlag = 1'b0;
    logic [3:0] n = 4'd3;
    logic [3:0] volume;

    int unsigned total = 0;
    int unsigned bad   = 0;

    envelope dut (
        .clk        (clk),
        .resetFlag  (resetFlag),
        .loop       (loop),
        .disableFlag(disableFlag),
        .n          (n),
        .volume     (volume)
    );

    always #5 clk = ~clk;

    task automatic tick(input int unsigned k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic restart();
        resetFlag = 1'b1;
        tick(1);
        resetFlag = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [3:0] exp);
        #1;
        total++;
        assert (volume === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, volume, exp);
        end
    endtask

    initial begin
        // n=3 decay without loop
        n = 4'd3; loop = 1'b0; disableFlag = 1'b0;
        restart();
        chk("reset_15", 4'd15);
        for (int i = 1; i <= 60; i++) begin
            tick(1);
            if (i % 4 == 0) chk("decay_n3", 4'(15 - i / 4));
            else if (i == 3) chk("hold_before_step", 4'd15);
        end
        for (int i = 0; i < 5; i++) begin
            tick(4);
            chk("hold_zero", 4'd0);
        end

        // Looping sawtooth
        loop = 1'b1;
        restart();
        chk("loop_reset", 4'd15);
        tick(60);
        chk("loop_zero_60", 4'd0);
        tick(3);
        chk("loop_zero_63", 4'd0);
        tick(1);
        chk("loop_wrap_64", 4'd15);
        tick(4);
        chk("loop_68", 4'd14);

        // Constant-volume mode mid-decay
        loop = 1'b0;
        restart();
        tick(5);
        chk("pre_const", 4'd14);
        disableFlag = 1'b1;
        chk("const_n3", 4'd3);
        n = 4'd9;
        chk("const_n9", 4'd9);
        n = 4'd3;
        tick(8);
        chk("const_hold", 4'd3);
        disableFlag = 1'b0;
        chk("const_cleared", 4'd12);

        // Reset while in constant mode shows n
        disableFlag = 1'b1;
        n = 4'd6;
        restart();
        chk("reset_const", 4'd6);
        disableFlag = 1'b0;
        chk("reset_const_decay", 4'd15);

        // n=0 steps every clock
        n = 4'd0;
        restart();
        chk("n0_reset", 4'd15);
        for (int i = 1; i <= 15; i++) begin
            tick(1);
            chk("n0_step", 4'(15 - i));
        end
        tick(3);
        chk("n0_hold", 4'd0);

        // n change takes effect at the next reload
        n = 4'd3;
        restart();
        tick(2);
        n = 4'd1;
        tick(2);
        chk("nchg_first", 4'd14);
        tick(1);
        chk("nchg_mid", 4'd14);
        tick(1);
        chk("nchg_second", 4'd13);

        // Restart mid-decay
        n = 4'd3;
        restart();
        tick(32);
        chk("mid_7", 4'd7);
        restart();
        chk("mid_restart", 4'd15);
        tick(3);
        chk("mid_hold", 4'd15);
        tick(1);
        chk("mid_step", 4'd14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
